wb_merge_unit: RTL and testbench

WB_MERGE_UNIT -- requirements
Module: wb_merge_unit

---
 rtl/wb_merge_unit_pkg.sv | 24 ++
 rtl/wb_cbuf.sv | 62 ++++++
 rtl/wb_merge_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_wb_merge_unit.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_merge_unit_pkg.sv
// Shared encodings and buffer-entry layout for the writeback merge unit.
// Entry data width follows WB_XLEN; the top XLEN is expected to match it.
package wb_merge_unit_pkg;

  localparam int WB_XLEN = 32;

  localparam logic [1:0] WB_SRC_ALU = 2'b00;
  localparam logic [1:0] WB_SRC_MEM = 2'b01;
  localparam logic [1:0] WB_SRC_PC4 = 2'b10;
  localparam logic [1:0] WB_SRC_CSR = 2'b11;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef struct packed {
    logic               is_fp;
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_ent_t;

endpackage

// File: rtl/wb_cbuf.sv
// In-order completion buffer holding long-latency results.
// A push into a full buffer is honoured only alongside a pop.
module wb_cbuf #(
  parameter int DEPTH = 4,
  parameter int W     = 38
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  // storage write; contents need no reset since count gates them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // pointers wrap naturally at DEPTH; count tracks push/pop balance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_merge_unit.sv
// Merges in-order pipeline writebacks with buffered long-latency
// completions onto registered integer and FP regfile write ports.
module wb_merge_unit
  import wb_merge_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LL_CH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_valid,
  input  logic [1:0]             wb_src,
  input  logic                   wb_is_fp,
  input  logic [4:0]             wb_rd,
  input  logic [XLEN-1:0]        alu_res,
  input  logic [XLEN-1:0]        pc4_res,
  input  logic [XLEN-1:0]        csr_res,
  input  logic [XLEN-1:0]        mem_rdata,
  input  logic [2:0]             mem_funct3,
  input  logic [1:0]             mem_addr_lo,
  input  logic [LL_CH-1:0]       ll_valid,
  output logic [LL_CH-1:0]       ll_ready,
  input  logic [LL_CH*XLEN-1:0]  ll_data,
  input  logic [LL_CH*5-1:0]     ll_rd,
  input  logic [LL_CH-1:0]       ll_is_fp,
  output logic                   int_we,
  output logic [4:0]             int_waddr,
  output logic [XLEN-1:0]        int_wdata,
  output logic                   fp_we,
  output logic [4:0]             fp_waddr,
  output logic [XLEN-1:0]        fp_wdata,
  output logic [$clog2(DEPTH):0] buf_count
);

  localparam int EW = $bits(wb_ent_t);

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_ld_res;
  logic [XLEN-1:0]  w_wb_res;
  logic             w_pl_int;
  logic             w_pl_fp;
  wb_ent_t          w_head;
  wb_ent_t          w_enq;
  logic [EW-1:0]    w_head_bits;
  logic             w_full;
  logic             w_empty;
  logic             w_hd_int;
  logic             w_hd_fp;
  logic             w_hd_nul;
  logic             w_pop;
  logic             w_push;
  logic             w_gnt_vld;
  logic [1:0]       w_gnt;
  logic [1:0]       r_rr;
  logic [LL_CH-1:0] w_ready;
  logic             r_int_we;
  logic [4:0]       r_int_waddr;
  logic [XLEN-1:0]  r_int_wdata;
  logic             r_fp_we;
  logic [4:0]       r_fp_waddr;
  logic [XLEN-1:0]  r_fp_wdata;

  // load lane select and extension; FP loads keep the raw word
  always_comb begin
    w_byte   = mem_rdata[{mem_addr_lo, 3'b000} +: 8];
    w_half   = mem_addr_lo[1] ? mem_rdata[31:16]
                              : mem_rdata[15:0];
    w_ld_res = mem_rdata;
    if (!wb_is_fp) begin
      unique case (1'b1)
        (mem_funct3 == LOAD_LB):
          w_ld_res = {{(XLEN-8){w_byte[7]}}, w_byte};
        (mem_funct3 == LOAD_LH):
          w_ld_res = {{(XLEN-16){w_half[15]}}, w_half};
        (mem_funct3 == LOAD_LBU):
          w_ld_res = {{(XLEN-8){1'b0}}, w_byte};
        (mem_funct3 == LOAD_LHU):
          w_ld_res = {{(XLEN-16){1'b0}}, w_half};
        (mem_funct3 == LOAD_LW):
          w_ld_res = mem_rdata;
        default:
          w_ld_res = mem_rdata;
      endcase
    end
  end

  // pipeline result select
  always_comb begin
    w_wb_res = alu_res;
    unique case (1'b1)
      (wb_src == WB_SRC_ALU): w_wb_res = alu_res;
      (wb_src == WB_SRC_MEM): w_wb_res = w_ld_res;
      (wb_src == WB_SRC_PC4): w_wb_res = pc4_res;
      (wb_src == WB_SRC_CSR): w_wb_res = csr_res;
      default:                w_wb_res = alu_res;
    endcase
  end

  assign w_pl_int = wb_valid && !wb_is_fp
                 && (wb_rd != 5'd0);
  assign w_pl_fp  = wb_valid && wb_is_fp;

  assign w_head   = w_head_bits;

  assign w_hd_int = !w_empty && !w_head.is_fp
                 && (w_head.rd != 5'd0) && !w_pl_int;
  assign w_hd_fp  = !w_empty && w_head.is_fp && !w_pl_fp;
  assign w_hd_nul = !w_empty && !w_head.is_fp
                 && (w_head.rd == 5'd0);
  assign w_pop    = w_hd_int || w_hd_fp || w_hd_nul;

  // round-robin grant: first valid channel at or after r_rr
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int i = LL_CH-1; i >= 0; i--) begin
      for (int j = 0; j < LL_CH; j++) begin
        if (ll_valid[j] &&
            j == (int'(r_rr) + i) % LL_CH) begin
          w_gnt_vld = 1'b1;
          w_gnt     = 2'(j);
        end
      end
    end
  end

  assign w_push = rst_n && w_gnt_vld
               && (!w_full || w_pop);

  // ready only on the granted channel when space exists
  always_comb begin
    w_ready = '0;
    for (int j = 0; j < LL_CH; j++) begin
      w_ready[j] = w_push && (w_gnt == 2'(j));
    end
  end

  assign ll_ready = w_ready;

  // payload of the granted channel
  always_comb begin
    w_enq = '0;
    for (int j = 0; j < LL_CH; j++) begin
      if (w_gnt == 2'(j)) begin
        w_enq.is_fp = ll_is_fp[j];
        w_enq.rd    = ll_rd[j*5 +: 5];
        w_enq.data  = ll_data[j*XLEN +: XLEN];
      end
    end
  end

  wb_cbuf #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_cbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_enq),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_count (buf_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // pointer moves one past the channel just enqueued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_push) begin
      r_rr <= (w_gnt == 2'(LL_CH-1)) ? 2'd0
                                     : w_gnt + 2'd1;
    end
  end

  // integer port: pipeline first, buffer head otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_we    <= 1'b0;
      r_int_waddr <= '0;
      r_int_wdata <= '0;
    end else begin
      r_int_we <= w_pl_int || w_hd_int;
      if (w_pl_int) begin
        r_int_waddr <= wb_rd;
        r_int_wdata <= w_wb_res;
      end else if (w_hd_int) begin
        r_int_waddr <= w_head.rd;
        r_int_wdata <= w_head.data;
      end
    end
  end

  // FP port: pipeline first, buffer head otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fp_we    <= 1'b0;
      r_fp_waddr <= '0;
      r_fp_wdata <= '0;
    end else begin
      r_fp_we <= w_pl_fp || w_hd_fp;
      if (w_pl_fp) begin
        r_fp_waddr <= wb_rd;
        r_fp_wdata <= w_wb_res;
      end else if (w_hd_fp) begin
        r_fp_waddr <= w_head.rd;
        r_fp_wdata <= w_head.data;
      end
    end
  end

  assign int_we    = r_int_we;
  assign int_waddr = r_int_waddr;
  assign int_wdata = r_int_wdata;
  assign fp_we     = r_fp_we;
  assign fp_waddr  = r_fp_waddr;
  assign fp_wdata  = r_fp_wdata;

endmodule

// File: tb/tb_wb_merge_unit.sv
// Directed bench for wb_merge_unit with a queue-based reference model.
// Inputs change 1 time unit after posedge; the model checks on negedge.
module tb_wb_merge_unit;

  localparam int NCH  = 2;
  localparam int NDEP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [1:0]  wb_src;
  logic        wb_is_fp;
  logic [4:0]  wb_rd;
  logic [31:0] alu_res, pc4_res, csr_res, mem_rdata;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [1:0]  ll_valid, ll_ready;
  logic [63:0] ll_data;
  logic [9:0]  ll_rd;
  logic [1:0]  ll_is_fp;
  logic        int_we, fp_we;
  logic [4:0]  int_waddr, fp_waddr;
  logic [31:0] int_wdata, fp_wdata;
  logic [2:0]  buf_count;

  wb_merge_unit #(.XLEN(32), .LL_CH(NCH), .DEPTH(NDEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_src(wb_src),
    .wb_is_fp(wb_is_fp), .wb_rd(wb_rd),
    .alu_res(alu_res), .pc4_res(pc4_res),
    .csr_res(csr_res), .mem_rdata(mem_rdata),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .ll_valid(ll_valid), .ll_ready(ll_ready),
    .ll_data(ll_data), .ll_rd(ll_rd), .ll_is_fp(ll_is_fp),
    .int_we(int_we), .int_waddr(int_waddr),
    .int_wdata(int_wdata),
    .fp_we(fp_we), .fp_waddr(fp_waddr), .fp_wdata(fp_wdata),
    .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit        fp;
    bit [4:0]  rd;
    bit [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          rr;
  bit          e_iwe, e_fwe;
  logic [4:0]  e_iwa, e_fwa;
  logic [31:0] e_iwd, e_fwd;
  int          e_cnt;

  function automatic logic [31:0] m_result();
    logic [31:0] b, hw;
    b  = (mem_rdata >> (8 * mem_addr_lo)) & 32'hFF;
    hw = (mem_rdata >> (16 * mem_addr_lo[1])) & 32'hFFFF;
    case (wb_src)
      2'd0: return alu_res;
      2'd2: return pc4_res;
      2'd3: return csr_res;
      default: begin
        if (wb_is_fp) return mem_rdata;
        case (mem_funct3)
          3'd0: return (b >= 128) ? b - 32'd256 : b;
          3'd1: return (hw >= 32768) ? hw - 32'd65536 : hw;
          3'd4: return b;
          3'd5: return hw;
          default: return mem_rdata;
        endcase
      end
    endcase
  endfunction

  task automatic model_step();
    bit pl_i, pl_f, hi, hf, pop;
    int g;
    logic [1:0] er;
    logic [31:0] res;
    ent_t h, n;
    pl_i = wb_valid && !wb_is_fp && (wb_rd != 0);
    pl_f = wb_valid && wb_is_fp;
    res  = m_result();
    hi = 0; hf = 0; pop = 0;
    if (q.size() > 0) begin
      h = q[0];
      if (h.fp) begin
        hf = !pl_f; pop = hf;
      end else if (h.rd == 0) begin
        pop = 1;
      end else begin
        hi = !pl_i; pop = hi;
      end
    end
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (rr + k) % NCH;
      if (g < 0 && ((ll_valid >> c) & 2'd1) != 0) g = c;
    end
    er = '0;
    if (g >= 0 && (q.size() < NDEP || pop)) er = 2'(1 << g);
    chk("ll_ready", ll_ready, er);
    e_iwe = pl_i || hi;
    if (pl_i) begin e_iwa = wb_rd; e_iwd = res; end
    else if (hi) begin e_iwa = h.rd; e_iwd = h.d; end
    e_fwe = pl_f || hf;
    if (pl_f) begin e_fwa = wb_rd; e_fwd = res; end
    else if (hf) begin e_fwa = h.rd; e_fwd = h.d; end
    if (pop) void'(q.pop_front());
    if (er != 0) begin
      n.fp = 1'((ll_is_fp >> g));
      n.rd = 5'((ll_rd >> (g * 5)));
      n.d  = 32'((ll_data >> (g * 32)));
      q.push_back(n);
      rr = (g + 1) % NCH;
    end
    e_cnt = q.size();
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      rr = 0; e_iwe = 0; e_fwe = 0; e_cnt = 0;
      chk("rst_int_we", int_we, 0);
      chk("rst_int_waddr", int_waddr, 0);
      chk("rst_int_wdata", int_wdata, 0);
      chk("rst_fp_we", fp_we, 0);
      chk("rst_fp_waddr", fp_waddr, 0);
      chk("rst_fp_wdata", fp_wdata, 0);
      chk("rst_buf_count", buf_count, 0);
      chk("rst_ll_ready", ll_ready, 0);
    end else begin
      chk("int_we", int_we, e_iwe);
      if (e_iwe) begin
        chk("int_waddr", int_waddr, e_iwa);
        chk("int_wdata", int_wdata, e_iwd);
      end
      chk("fp_we", fp_we, e_fwe);
      if (e_fwe) begin
        chk("fp_waddr", fp_waddr, e_fwa);
        chk("fp_wdata", fp_wdata, e_fwd);
      end
      chk("buf_count", buf_count, e_cnt);
      model_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input bit v, input bit fp,
                    input logic [1:0] src,
                    input logic [4:0] rd);
    wb_valid = v; wb_is_fp = fp; wb_src = src; wb_rd = rd;
  endtask

  task automatic ll(input int ch, input bit fp,
                    input logic [4:0] rd,
                    input logic [31:0] d);
    if (ch == 0) begin
      ll_is_fp[0] = fp; ll_rd[4:0] = rd; ll_data[31:0] = d;
    end else begin
      ll_is_fp[1] = fp; ll_rd[9:5] = rd; ll_data[63:32] = d;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wb(0, 0, 2'd0, 5'd0);
    alu_res = 32'h1111_1111;
    pc4_res = 32'h2222_2222;
    csr_res = 32'h3333_3333;
    mem_rdata = '0; mem_funct3 = '0; mem_addr_lo = '0;
    ll_valid = '0; ll_data = '0; ll_rd = '0; ll_is_fp = '0;
    cyc(); cyc();
    rst_n = 1'b1;

    // load extension
    mem_rdata = 32'h0000_80FF; mem_addr_lo = 2'd1;
    mem_funct3 = 3'b000; wb(1, 0, 2'd1, 5'd3);
    cyc();
    chk("lb_we", int_we, 1);
    chk("lb_data", int_wdata, 32'hFFFF_FF80);
    mem_funct3 = 3'b100; cyc();
    chk("lbu_data", int_wdata, 32'h0000_0080);
    mem_rdata = 32'h8001_0000; mem_addr_lo = 2'd2;
    mem_funct3 = 3'b001; cyc();
    chk("lh_data", int_wdata, 32'hFFFF_8001);
    mem_funct3 = 3'b101; cyc();
    chk("lhu_data", int_wdata, 32'h0000_8001);
    mem_funct3 = 3'b010; mem_addr_lo = 2'd0; cyc();
    chk("lw_data", int_wdata, 32'h8001_0000);
    mem_rdata = 32'h0000_80FF; mem_addr_lo = 2'd1;
    mem_funct3 = 3'b000; wb(1, 1, 2'd1, 5'd4); cyc();
    chk("fpld_we", fp_we, 1);
    chk("fpld_data", fp_wdata, 32'h0000_80FF);
    wb(1, 0, 2'd2, 5'd6); cyc();
    chk("pc4_data", int_wdata, 32'h2222_2222);
    wb(1, 0, 2'd3, 5'd7); cyc();
    chk("csr_data", int_wdata, 32'h3333_3333);
    wb(0, 0, 2'd0, 5'd0); cyc();

    // x0 suppression with a same-cycle completion
    wb(1, 0, 2'd0, 5'd0);
    ll(0, 0, 5'd5, 32'hAAAA_0005); ll_valid = 2'b01;
    #1 chk("x0_ready", ll_ready, 2'b01);
    cyc();
    chk("x0_we", int_we, 0);
    chk("x0_cnt", buf_count, 1);
    wb(0, 0, 2'd0, 5'd0); ll_valid = 2'b00;
    cyc();
    chk("x5_we", int_we, 1);
    chk("x5_addr", int_waddr, 5);
    chk("x5_data", int_wdata, 32'hAAAA_0005);

    // round robin from a fresh reset, int port held busy
    rst_n = 1'b0;
    #1 chk("rr_rst_cnt", buf_count, 0);
    cyc();
    rst_n = 1'b1;
    wb(1, 0, 2'd0, 5'd7);
    ll(0, 0, 5'd10, 32'h0000_00C0);
    ll(1, 0, 5'd11, 32'h0000_00C1);
    ll_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_ready", ll_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
    end
    chk("rr_cnt", buf_count, 4);

    // port conflict holds the head
    ll_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_cnt", buf_count, 4);
      chk("hold_addr", int_waddr, 7);
    end

    // FP pipeline write frees int port; full buffer accepts with pop
    wb(1, 1, 2'd0, 5'd2);
    ll(0, 0, 5'd12, 32'h0000_00D0); ll_valid = 2'b01;
    #1 chk("full_ready", ll_ready, 2'b01);
    cyc();
    chk("dual_int_we", int_we, 1);
    chk("dual_int_addr", int_waddr, 10);
    chk("dual_int_data", int_wdata, 32'h0000_00C0);
    chk("dual_fp_we", fp_we, 1);
    chk("dual_fp_addr", fp_waddr, 2);
    chk("full_cnt", buf_count, 4);
    wb(0, 0, 2'd0, 5'd0); ll_valid = 2'b00;
    for (int i = 0; i < 4; i++) cyc();
    chk("drain_addr", int_waddr, 12);
    chk("drain_data", int_wdata, 32'h0000_00D0);
    chk("drain_cnt", buf_count, 0);

    // in-order drain: blocked FP head stalls an int entry
    wb(1, 1, 2'd0, 5'd1);
    ll(1, 1, 5'd20, 32'h0000_00F1); ll_valid = 2'b10;
    cyc();
    ll(0, 0, 5'd21, 32'h0000_00E1); ll_valid = 2'b01;
    cyc();
    ll_valid = 2'b00;
    cyc();
    chk("order_int_we", int_we, 0);
    chk("order_cnt", buf_count, 2);
    cyc();
    chk("order_int_we2", int_we, 0);
    wb(0, 0, 2'd0, 5'd0);
    cyc();
    chk("order_fp_we", fp_we, 1);
    chk("order_fp_addr", fp_waddr, 20);
    chk("order_int_we3", int_we, 0);
    cyc();
    chk("order_int_we4", int_we, 1);
    chk("order_int_addr", int_waddr, 21);

    // buffered rd=0 entry pops silently
    ll(1, 0, 5'd0, 32'h0000_0BAD); ll_valid = 2'b10;
    cyc();
    chk("rd0_cnt", buf_count, 1);
    ll_valid = 2'b00;
    cyc();
    chk("rd0_we", int_we, 0);
    chk("rd0_cnt2", buf_count, 0);

    // reset with three entries buffered
    wb(1, 0, 2'd0, 5'd7);
    ll(0, 0, 5'd13, 32'h0000_0013);
    ll(1, 0, 5'd14, 32'h0000_0014);
    ll_valid = 2'b11;
    cyc(); cyc(); cyc();
    chk("mid_cnt", buf_count, 3);
    ll_valid = 2'b00;
    rst_n = 1'b0;
    #1 chk("mid_rst_cnt", buf_count, 0);
    wb(0, 0, 2'd0, 5'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_int_we", int_we, 0);
      chk("post_rst_fp_we", fp_we, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
